// File: rtl/uart_spi_pkg.sv
// Shared types and defaults for the UART/SPI loopback bridge.
package uart_spi_pkg;

    localparam int unsigned DATA_W = 8;

    typedef enum logic [1:0] {
        IDLE,
        START,
        WAIT_DONE
    } bridge_state_t;

endpackage

// File: rtl/byte_fifo.sv
// Show-ahead byte FIFO with a level counter; pointers wrap on a power-of-two depth.
module byte_fifo #(
    parameter int unsigned DATA_W     = 8,
    parameter int unsigned FIFO_DEPTH = 4
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic                          push,
    input  logic [DATA_W-1:0]             push_data,
    input  logic                          pop,
    output logic [DATA_W-1:0]             head,
    output logic                          full,
    output logic                          empty,
    output logic [$clog2(FIFO_DEPTH):0]   level
);

    localparam int unsigned PTR_W = $clog2(FIFO_DEPTH);
    localparam int unsigned LVL_W = PTR_W + 1;

    logic [DATA_W-1:0] mem_q [FIFO_DEPTH];
    logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
    logic [LVL_W-1:0]  level_q, level_d;
    logic              push_ok;
    logic              pop_ok;

    assign full  = (level_q == LVL_W'(FIFO_DEPTH));
    assign empty = (level_q == '0);
    assign level = level_q;
    assign head  = mem_q[rd_ptr_q];

    // A full FIFO still accepts a push when a slot frees in the same cycle.
    assign pop_ok  = pop && !empty;
    assign push_ok = push && (!full || pop_ok);

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        level_d  = level_q;
        if (push_ok) wr_ptr_d = wr_ptr_q + PTR_W'(1);
        if (pop_ok)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
        case ({push_ok, pop_ok})
            2'b10:   level_d = level_q + LVL_W'(1);
            2'b01:   level_d = level_q - LVL_W'(1);
            default: level_d = level_q;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            level_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            level_q  <= level_d;
        end
    end

    always_ff @(posedge clk) begin
        if (push_ok) mem_q[wr_ptr_q] <= push_data;
    end

endmodule

// File: rtl/uart_spi_bridge.sv
// Bridges UART RX bytes to single-byte SPI transfers and returns MISO bytes to UART TX,
// with sticky overflow/overrun/timeout flags.
module uart_spi_bridge #(
    parameter int unsigned DATA_W      = uart_spi_pkg::DATA_W,
    parameter int unsigned FIFO_DEPTH  = 4,
    parameter int unsigned TIMEOUT_CYC = 4096
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic [DATA_W-1:0]             uart_rx_data,
    input  logic                          uart_rx_valid,
    input  logic                          uart_tx_ready,
    output logic [DATA_W-1:0]             uart_tx_data,
    output logic                          uart_tx_start,
    output logic [DATA_W-1:0]             spi_tx_data,
    output logic                          spi_start,
    input  logic                          spi_tx_done,
    input  logic [DATA_W-1:0]             spi_rx_data,
    input  logic                          spi_rx_valid,
    input  logic                          clear_flags,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_level,
    output logic                          fifo_overflow,
    output logic                          rx_overrun,
    output logic                          spi_timeout
);

    import uart_spi_pkg::*;

    localparam int unsigned TMR_W = $clog2(TIMEOUT_CYC);

    bridge_state_t     state_q, state_d;
    logic [TMR_W-1:0]  timer_q, timer_d;
    logic [DATA_W-1:0] spi_tx_data_q;
    logic [DATA_W-1:0] hold_q;
    logic              hold_full_q, hold_full_d;
    logic              overflow_q, overrun_q, timeout_q;

    logic [DATA_W-1:0] fifo_head;
    logic              fifo_full;
    logic              fifo_empty;
    logic              fifo_pop;
    logic              load_tx;
    logic              timeout_set;
    logic              drain;
    logic              load_hold;
    logic              overrun_set;
    logic              overflow_set;

    byte_fifo #(
        .DATA_W     (DATA_W),
        .FIFO_DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk       (clk),
        .reset     (reset),
        .push      (uart_rx_valid),
        .push_data (uart_rx_data),
        .pop       (fifo_pop),
        .head      (fifo_head),
        .full      (fifo_full),
        .empty     (fifo_empty),
        .level     (fifo_level)
    );

    always_comb begin
        state_d     = state_q;
        timer_d     = timer_q;
        fifo_pop    = 1'b0;
        load_tx     = 1'b0;
        spi_start   = 1'b0;
        timeout_set = 1'b0;
        case (state_q)
            IDLE: begin
                if (!fifo_empty) begin
                    fifo_pop = 1'b1;
                    load_tx  = 1'b1;
                    state_d  = START;
                end
            end
            START: begin
                spi_start = 1'b1;
                timer_d   = '0;
                state_d   = WAIT_DONE;
            end
            WAIT_DONE: begin
                if (spi_tx_done) begin
                    state_d = IDLE;
                end else if (timer_q == TMR_W'(TIMEOUT_CYC - 1)) begin
                    // Abort: the in-flight byte is lost.
                    timeout_set = 1'b1;
                    state_d     = IDLE;
                end else begin
                    timer_d = timer_q + TMR_W'(1);
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Return path: a draining hold register can take a new byte in the same cycle.
    always_comb begin
        drain        = hold_full_q && uart_tx_ready;
        load_hold    = spi_rx_valid && (!hold_full_q || drain);
        overrun_set  = spi_rx_valid && hold_full_q && !drain;
        hold_full_d  = load_hold || (hold_full_q && !drain);
        overflow_set = uart_rx_valid && fifo_full && !fifo_pop;
    end

    assign spi_tx_data   = spi_tx_data_q;
    assign uart_tx_data  = hold_q;
    assign uart_tx_start = drain;
    assign fifo_overflow = overflow_q;
    assign rx_overrun    = overrun_q;
    assign spi_timeout   = timeout_q;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q       <= IDLE;
            timer_q       <= '0;
            spi_tx_data_q <= '0;
            hold_q        <= '0;
            hold_full_q   <= 1'b0;
            overflow_q    <= 1'b0;
            overrun_q     <= 1'b0;
            timeout_q     <= 1'b0;
        end else begin
            state_q     <= state_d;
            timer_q     <= timer_d;
            hold_full_q <= hold_full_d;
            if (load_tx)   spi_tx_data_q <= fifo_head;
            if (load_hold) hold_q        <= spi_rx_data;
            // Clearing wins over a flag raised in the same cycle.
            overflow_q <= !clear_flags && (overflow_q || overflow_set);
            overrun_q  <= !clear_flags && (overrun_q || overrun_set);
            timeout_q  <= !clear_flags && (timeout_q || timeout_set);
        end
    end

endmodule

// File: tb/tb_uart_spi_bridge.sv
// Directed self-checking bench for uart_spi_bridge.
module tb_uart_spi_bridge;

    localparam int unsigned DW    = 8;
    localparam int unsigned DEPTH = 4;
    localparam int unsigned TMO   = 4096;

    logic                        clk;
    logic                        reset;
    logic [DW-1:0]               uart_rx_data;
    logic                        uart_rx_valid;
    logic                        uart_tx_ready;
    logic [DW-1:0]               uart_tx_data;
    logic                        uart_tx_start;
    logic [DW-1:0]               spi_tx_data;
    logic                        spi_start;
    logic                        spi_tx_done;
    logic [DW-1:0]               spi_rx_data;
    logic                        spi_rx_valid;
    logic                        clear_flags;
    logic [$clog2(DEPTH):0]      fifo_level;
    logic                        fifo_overflow;
    logic                        rx_overrun;
    logic                        spi_timeout;

    int checks = 0;
    int errors = 0;

    uart_spi_bridge #(
        .DATA_W      (DW),
        .FIFO_DEPTH  (DEPTH),
        .TIMEOUT_CYC (TMO)
    ) dut (
        .clk           (clk),
        .reset         (reset),
        .uart_rx_data  (uart_rx_data),
        .uart_rx_valid (uart_rx_valid),
        .uart_tx_ready (uart_tx_ready),
        .uart_tx_data  (uart_tx_data),
        .uart_tx_start (uart_tx_start),
        .spi_tx_data   (spi_tx_data),
        .spi_start     (spi_start),
        .spi_tx_done   (spi_tx_done),
        .spi_rx_data   (spi_rx_data),
        .spi_rx_valid  (spi_rx_valid),
        .clear_flags   (clear_flags),
        .fifo_level    (fifo_level),
        .fifo_overflow (fifo_overflow),
        .rx_overrun    (rx_overrun),
        .spi_timeout   (spi_timeout)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic push_byte(input logic [7:0] b);
        uart_rx_data  = b;
        uart_rx_valid = 1'b1;
        @(negedge clk);
        uart_rx_valid = 1'b0;
    endtask

    // Called while START or WAIT_DONE; returns one cycle after the FSM is back in IDLE.
    task automatic finish_xfer();
        @(negedge clk);
        spi_tx_done = 1'b1;
        @(negedge clk);
        spi_tx_done = 1'b0;
        @(negedge clk);
    endtask

    // Completes the current transfer and expects the next one to start 2 cycles later.
    task automatic done_expect(input string tag, input logic [7:0] exp);
        finish_xfer();
        chk({tag, "_start"}, spi_start, 1);
        chk({tag, "_data"}, spi_tx_data, exp);
    endtask

    initial begin
        int starts;
        reset = 1'b0;
        uart_rx_data = '0; uart_rx_valid = 1'b0; uart_tx_ready = 1'b0;
        spi_tx_done = 1'b0; spi_rx_data = '0; spi_rx_valid = 1'b0; clear_flags = 1'b0;
        repeat (2) @(negedge clk);
        chk("rst_spi_start", spi_start, 0);
        chk("rst_uart_tx_start", uart_tx_start, 0);
        chk("rst_spi_tx_data", spi_tx_data, 0);
        chk("rst_uart_tx_data", uart_tx_data, 0);
        chk("rst_level", fifo_level, 0);
        chk("rst_flags", {fifo_overflow, rx_overrun, spi_timeout}, 0);
        reset = 1'b1;
        @(negedge clk);

        // Single byte, 2-cycle latency to spi_start
        push_byte(8'hA5);
        chk("t1_level1", fifo_level, 1);
        chk("t1_nostart", spi_start, 0);
        @(negedge clk);
        chk("t1_start", spi_start, 1);
        chk("t1_data", spi_tx_data, 8'hA5);
        chk("t1_level0", fifo_level, 0);
        @(negedge clk);
        chk("t1_start_pulse", spi_start, 0);
        finish_xfer();
        chk("t1_idle_start", spi_start, 0);
        chk("t1_idle_level", fifo_level, 0);

        // Fill to depth with transfer stalled, then overflow
        for (int i = 1; i <= 5; i++) push_byte(8'(i));
        chk("t2_level4", fifo_level, 4);
        chk("t2_no_ovf", fifo_overflow, 0);
        chk("t2_inflight", spi_tx_data, 8'h01);
        push_byte(8'h06);
        chk("t2_level_full", fifo_level, 4);
        chk("t2_ovf", fifo_overflow, 1);
        done_expect("t2_b2", 8'h02);
        done_expect("t2_b3", 8'h03);
        done_expect("t2_b4", 8'h04);
        done_expect("t2_b5", 8'h05);
        finish_xfer();
        chk("t2_drained_start", spi_start, 0);
        chk("t2_drained_level", fifo_level, 0);
        clear_flags = 1'b1;
        @(negedge clk);
        clear_flags = 1'b0;
        chk("t2_ovf_clr", fifo_overflow, 0);

        // Return path
        spi_rx_data = 8'h3C; spi_rx_valid = 1'b1; uart_tx_ready = 1'b1;
        @(negedge clk);
        spi_rx_valid = 1'b0;
        chk("t3_tx_start", uart_tx_start, 1);
        chk("t3_tx_data", uart_tx_data, 8'h3C);
        @(negedge clk);
        chk("t3_tx_pulse", uart_tx_start, 0);
        chk("t3_tx_hold", uart_tx_data, 8'h3C);
        uart_tx_ready = 1'b0;
        spi_rx_data = 8'h11; spi_rx_valid = 1'b1;
        @(negedge clk);
        spi_rx_data = 8'h22;
        @(negedge clk);
        spi_rx_valid = 1'b0;
        chk("t3_ovr_data", uart_tx_data, 8'h11);
        chk("t3_ovr", rx_overrun, 1);
        chk("t3_ovr_nostart", uart_tx_start, 0);
        uart_tx_ready = 1'b1;
        #1;
        chk("t3_ready_start", uart_tx_start, 1);
        @(negedge clk);
        uart_tx_ready = 1'b0;
        spi_rx_data = 8'h44; spi_rx_valid = 1'b1;
        @(negedge clk);
        spi_rx_data = 8'h55; clear_flags = 1'b1;
        @(negedge clk);
        spi_rx_valid = 1'b0; clear_flags = 1'b0;
        chk("t3_clr_prio", rx_overrun, 0);
        chk("t3_kept44", uart_tx_data, 8'h44);
        uart_tx_ready = 1'b1; spi_rx_data = 8'h66; spi_rx_valid = 1'b1;
        @(negedge clk);
        spi_rx_valid = 1'b0;
        chk("t3_drain_load", uart_tx_data, 8'h66);
        chk("t3_drain_noovr", rx_overrun, 0);
        chk("t3_drain_start", uart_tx_start, 1);
        @(negedge clk);
        uart_tx_ready = 1'b0;
        chk("t3_empty", uart_tx_start, 0);

        // Timeout
        push_byte(8'h77);
        push_byte(8'h88);
        chk("t4_start", spi_start, 1);
        chk("t4_data", spi_tx_data, 8'h77);
        repeat (TMO) @(negedge clk);
        chk("t4_not_yet", spi_timeout, 0);
        @(negedge clk);
        chk("t4_timeout", spi_timeout, 1);
        chk("t4_idle", spi_start, 0);
        @(negedge clk);
        chk("t4_next_start", spi_start, 1);
        chk("t4_next_data", spi_tx_data, 8'h88);
        clear_flags = 1'b1;
        @(negedge clk);
        clear_flags = 1'b0;
        chk("t4_clr", spi_timeout, 0);
        finish_xfer();
        chk("t4_level", fifo_level, 0);

        // Async reset mid-transfer
        spi_rx_data = 8'h9A; spi_rx_valid = 1'b1;
        @(negedge clk);
        spi_rx_valid = 1'b0;
        for (int i = 0; i < 4; i++) push_byte(8'hB1 + 8'(i));
        chk("t5_level3", fifo_level, 3);
        chk("t5_inflight", spi_tx_data, 8'hB1);
        uart_tx_ready = 1'b1;
        #1;
        chk("t5_pre_txstart", uart_tx_start, 1);
        #2;
        reset = 1'b0;
        spi_tx_done = 1'b1;
        #1;
        chk("t5_rst_spi_start", spi_start, 0);
        chk("t5_rst_tx_start", uart_tx_start, 0);
        chk("t5_rst_spi_data", spi_tx_data, 0);
        chk("t5_rst_tx_data", uart_tx_data, 0);
        chk("t5_rst_level", fifo_level, 0);
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        spi_tx_done = 1'b0;
        starts = 0;
        repeat (6) begin
            @(negedge clk);
            if (spi_start) starts++;
        end
        chk("t5_no_start", starts, 0);
        chk("t5_post_level", fifo_level, 0);
        uart_tx_ready = 1'b0;
        push_byte(8'hC7);
        @(negedge clk);
        chk("t5_new_start", spi_start, 1);
        chk("t5_new_data", spi_tx_data, 8'hC7);
        finish_xfer();

        // Push and pop in the same cycle at full level
        for (int i = 0; i < 5; i++) push_byte(8'hD0 + 8'(i));
        chk("t6_level4", fifo_level, 4);
        spi_tx_done = 1'b1;
        @(negedge clk);
        spi_tx_done = 1'b0;
        uart_rx_data = 8'hD5; uart_rx_valid = 1'b1;
        @(negedge clk);
        uart_rx_valid = 1'b0;
        chk("t6_level_stays", fifo_level, 4);
        chk("t6_no_ovf", fifo_overflow, 0);
        chk("t6_start", spi_start, 1);
        chk("t6_data", spi_tx_data, 8'hD1);
        done_expect("t6_d2", 8'hD2);
        done_expect("t6_d3", 8'hD3);
        done_expect("t6_d4", 8'hD4);
        done_expect("t6_d5", 8'hD5);
        finish_xfer();
        chk("t6_level0", fifo_level, 0);

        // Pointer wrap over 3*DEPTH bytes
        for (int i = 0; i < 3 * DEPTH; i++) begin
            push_byte(8'h40 + 8'(i));
            @(negedge clk);
            chk("t6_wrap_start", spi_start, 1);
            chk("t6_wrap_data", spi_tx_data, 8'h40 + 8'(i));
            finish_xfer();
        end
        chk("t6_wrap_level", fifo_level, 0);
        chk("t6_wrap_ovf", fifo_overflow, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
